// File: rtl/imem_line_responder.sv
// -----------------------------------------------------------------------------
// imem_line_responder
//
// Memory-side responder for the instruction-cache refill protocol. It holds
// the backing instruction array and answers a refill request with the
// two-word line that contains the requested address. The even word is always
// returned first. The first beat appears LATENCY cycles after the request is
// captured. Each beat is then held until the cache acknowledges it.
//
// Optional feature macro: IMEM_RANGE_CHECK_EN
//   When defined, the module gains a MEM_WORDS parameter and an `err` output.
//   A line at or beyond MEM_WORDS still completes the full handshake, but it
//   returns zero data, and `err` pulses on the BEAT0 entry edge.
//
// Parameters
//   ADDR_W     word-address width (memory depth = 2**ADDR_W words)
//   DATA_W     instruction word width
//   LATENCY    idle cycles between request capture and first beat (1..15)
//   MEM_WORDS  populated word count (only with IMEM_RANGE_CHECK_EN)
//
// Ports
//   clk         clock, rising edge
//   reset       asynchronous active-high reset
//   mem_rd      refill request, level-held until the line completes
//   addr        word address of the missed instruction (sampled on capture)
//   write_done  cache acknowledge for the current beat (level)
//   mem_ready   beat data valid on mem_data
//   mem_data    refill word for the current beat (zero when not ready)
//   beat        index of the word being presented (0 even, 1 odd)
//   busy        refill in progress (state other than IDLE)
//   wr_en/wr_addr/wr_data  backdoor preload port, honoured only in IDLE
//   err         out-of-range line pulse (only with IMEM_RANGE_CHECK_EN)
// -----------------------------------------------------------------------------
module imem_line_responder #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 3
`ifdef IMEM_RANGE_CHECK_EN
    ,
    parameter int MEM_WORDS = 2 ** ADDR_W
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_rd,
    input  logic [ADDR_W-1:0] addr,
    input  logic              write_done,
    output logic              mem_ready,
    output logic [DATA_W-1:0] mem_data,
    output logic              beat,
    output logic              busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
`ifdef IMEM_RANGE_CHECK_EN
    ,
    output logic              err
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_BEAT0 = 3'd2,
        ST_BEAT1 = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [3:0]          r_count;
    logic [3:0]          w_count_next;
    logic [ADDR_W-2:0]   r_line;
    logic [ADDR_W-2:0]   w_line_next;
    logic                r_mem_ready;
    logic                r_beat;
    logic [DATA_W-1:0]   r_mem_data;
    logic                w_ready_next;
    logic                w_beat_next;
    logic [DATA_W-1:0]   w_data_next;
    logic [ADDR_W-1:0]   w_rd_index;

    logic [DATA_W-1:0]   r_mem [DEPTH];

    // The word select inside a line always comes from the beat index. The
    // request's own low address bit has no effect on the returned data.
    logic w_unused_addr_lsb;
    assign w_unused_addr_lsb = addr[0];

    // ------------------------------------------------------------------
    // Backing store. Reset does not clear it. Writes are accepted only
    // while idle, so the line cannot change under an active refill.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en && (r_state == ST_IDLE)) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_line_next  = r_line;
        case (r_state)
            ST_IDLE: begin
                if (mem_rd) begin
                    w_line_next  = addr[ADDR_W-1:1];
                    w_count_next = 4'(LATENCY - 1);
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A withdrawn request takes priority over the latency count.
                if (!mem_rd) begin
                    w_state_next = ST_IDLE;
                end else if (r_count == 4'd0) begin
                    w_state_next = ST_BEAT0;
                end else begin
                    w_count_next = r_count - 4'd1;
                end
            end
            ST_BEAT0: begin
                if (!mem_rd) begin
                    w_state_next = ST_IDLE;
                end else if (write_done) begin
                    w_state_next = ST_BEAT1;
                end
            end
            ST_BEAT1: begin
                // An acknowledge held high from BEAT0 completes this beat on
                // the following edge at the earliest. This is because each
                // edge advances by exactly one state.
                if (!mem_rd) begin
                    w_state_next = ST_IDLE;
                end else if (write_done) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!mem_rd) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output pre-decode from the next state. The outputs are then
    // registered, so they change on the same edge as the state and do not
    // depend combinationally on any input.
    // ------------------------------------------------------------------
    assign w_rd_index = {r_line, (w_state_next == ST_BEAT1)};

`ifdef IMEM_RANGE_CHECK_EN
    logic w_oob;
    logic w_err_next;
    logic r_err;

    assign w_oob      = (int'({1'b0, r_line, 1'b0}) >= MEM_WORDS);
    assign w_err_next = (r_state == ST_WAIT) && (w_state_next == ST_BEAT0) && w_oob;
`endif

    always_comb begin
        w_ready_next = (w_state_next == ST_BEAT0) || (w_state_next == ST_BEAT1);
        w_beat_next  = (w_state_next == ST_BEAT1);
        w_data_next  = '0;
        if (w_ready_next) begin
            w_data_next = r_mem[w_rd_index];
`ifdef IMEM_RANGE_CHECK_EN
            if (w_oob) begin
                w_data_next = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_count     <= 4'd0;
            r_line      <= '0;
            r_mem_ready <= 1'b0;
            r_beat      <= 1'b0;
            r_mem_data  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_count     <= w_count_next;
            r_line      <= w_line_next;
            r_mem_ready <= w_ready_next;
            r_beat      <= w_beat_next;
            r_mem_data  <= w_data_next;
        end
    end

`ifdef IMEM_RANGE_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err_next;
        end
    end

    assign err = r_err;
`endif

    assign mem_ready = r_mem_ready;
    assign mem_data  = r_mem_data;
    assign beat      = r_beat;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_imem_line_responder.sv
// -----------------------------------------------------------------------------
// tb_imem_line_responder
//
// Directed and randomized refills are checked against a plain array model of
// the instruction memory. The expected timing comes from the protocol rules:
// - capture at edge N;
// - first beat LATENCY edges later;
// - each beat held until an acknowledge is sampled;
// - DONE held until the request drops.
// -----------------------------------------------------------------------------
module tb_imem_line_responder;

    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int LAT = 3;

    logic          clk        = 1'b0;
    logic          reset      = 1'b0;
    logic          mem_rd     = 1'b0;
    logic [AW-1:0] addr       = '0;
    logic          write_done = 1'b0;
    logic          mem_ready;
    logic [DW-1:0] mem_data;
    logic          beat;
    logic          busy;
    logic          wr_en      = 1'b0;
    logic [AW-1:0] wr_addr    = '0;
    logic [DW-1:0] wr_data    = '0;
`ifdef IMEM_RANGE_CHECK_EN
    logic          err;
`endif

    always #5 clk = ~clk;

    imem_line_responder #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .LATENCY(LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_rd    (mem_rd),
        .addr      (addr),
        .write_done(write_done),
        .mem_ready (mem_ready),
        .mem_data  (mem_data),
        .beat      (beat),
        .busy      (busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
`ifdef IMEM_RANGE_CHECK_EN
        ,
        .err       (err)
`endif
    );

    logic [DW-1:0] ref_mem [2**AW];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en   = 1'b0;
        ref_mem[a] = d;
        $display("[TB] preload mem[%02h]=%08h", a, d);
    endtask

    // Full refill of the line holding `a`. The acknowledge for beat 0 is
    // delayed by d0 cycles and the acknowledge for beat 1 by d1 cycles.
    // The request is held `hold` cycles into DONE. When wr_same is set, a
    // backdoor write to the even word lands on the capture edge.
    task automatic refill(input logic [AW-1:0] a, input int d0, input int d1,
                          input int hold, input bit wr_same);
        logic [AW-1:0] base;
        logic [DW-1:0] ev;
        logic [DW-1:0] od;
        base       = {a[AW-1:1], 1'b0};
        mem_rd     = 1'b1;
        addr       = a;
        write_done = 1'b0;
        if (wr_same) begin
            wr_en   = 1'b1;
            wr_addr = base;
            wr_data = $urandom;
            ref_mem[base] = wr_data;
        end
        step();                      // capture edge N
        wr_en = 1'b0;
        ev    = ref_mem[base];
        od    = ref_mem[base | 8'h01];
        addr  = AW'($urandom);       // addr is only sampled on capture
        // A write attempted while busy must be ignored.
        wr_en   = 1'b1;
        wr_addr = base;
        wr_data = ~ev;
        for (int i = 0; i < LAT; i++) begin
            chk("wait_ready", {31'b0, mem_ready}, 32'd0);
            chk("wait_busy", {31'b0, busy}, 32'd1);
            chk("wait_data", mem_data, 32'd0);
            step();
            wr_en = 1'b0;
        end
        // Now at edge N+LAT: beat 0
        for (int i = 0; i < d0; i++) begin
            chk("b0_hold_data", mem_data, ev);
            chk("b0_hold_beat", {31'b0, beat}, 32'd0);
            step();
        end
        chk("b0_ready", {31'b0, mem_ready}, 32'd1);
        chk("b0_beat", {31'b0, beat}, 32'd0);
        chk("b0_data", mem_data, ev);
        write_done = 1'b1;
        step();
        chk("b1_ready", {31'b0, mem_ready}, 32'd1);
        chk("b1_beat", {31'b0, beat}, 32'd1);
        chk("b1_data", mem_data, od);
        if (d1 > 0) begin
            write_done = 1'b0;
            for (int i = 0; i < d1; i++) begin
                step();
                chk("b1_hold_data", mem_data, od);
                chk("b1_hold_ready", {31'b0, mem_ready}, 32'd1);
            end
            write_done = 1'b1;
        end
        step();                      // DONE
        write_done = 1'b0;
        chk("done_ready", {31'b0, mem_ready}, 32'd0);
        chk("done_data", mem_data, 32'd0);
        chk("done_busy", {31'b0, busy}, 32'd1);
        for (int i = 0; i < hold; i++) begin
            step();
            chk("held_ready", {31'b0, mem_ready}, 32'd0);
            chk("held_busy", {31'b0, busy}, 32'd1);
        end
        mem_rd = 1'b0;
        step();
        chk("idle_busy", {31'b0, busy}, 32'd0);
        chk("idle_ready", {31'b0, mem_ready}, 32'd0);
        $display("[TB] refill addr=%02h d0=%0d d1=%0d hold=%0d wr_same=%0d even=%08h odd=%08h",
                 a, d0, d1, hold, wr_same, ev, od);
    endtask

    initial begin
        // Asynchronous reset before any clock edge
        #1 reset = 1'b1;
        #1;
        chk("rst_ready", {31'b0, mem_ready}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_beat", {31'b0, beat}, 32'd0);
        chk("rst_data", mem_data, 32'd0);
`ifdef IMEM_RANGE_CHECK_EN
        chk("rst_err", {31'b0, err}, 32'd0);
`endif
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        $display("[TB] reset released");

        for (int i = 0; i < 2**AW; i++) begin
            wr_en   = 1'b1;
            wr_addr = AW'(i);
            wr_data = $urandom;
            ref_mem[i] = wr_data;
            step();
        end
        wr_en = 1'b0;

        // Basic refill with odd address: even word first
        preload(8'h10, 32'hAAAA0001);
        preload(8'h11, 32'hAAAA0002);
        refill(8'h11, 0, 0, 0, 1'b0);

        // Held request, then delayed acknowledge of 5 cycles
        refill(8'h11, 0, 0, 4, 1'b0);
        refill(8'h10, 5, 1, 0, 1'b0);

        // Backdoor write on the capture edge uses the post-write contents
        refill(8'h20, 0, 0, 0, 1'b1);

        // Abort during WAIT
        mem_rd = 1'b1;
        addr   = 8'h30;
        step();
        chk("abw_busy_on", {31'b0, busy}, 32'd1);
        mem_rd = 1'b0;
        step();
        chk("abw_busy_off", {31'b0, busy}, 32'd0);
        for (int i = 0; i < LAT + 1; i++) begin
            chk("abw_ready", {31'b0, mem_ready}, 32'd0);
            step();
        end
        $display("[TB] abort in WAIT");

        // Abort during BEAT1
        mem_rd = 1'b1;
        addr   = 8'h41;
        step();
        repeat (LAT) step();
        chk("ab1_b0_ready", {31'b0, mem_ready}, 32'd1);
        write_done = 1'b1;
        step();
        chk("ab1_b1_beat", {31'b0, beat}, 32'd1);
        mem_rd     = 1'b0;
        write_done = 1'b0;
        step();
        chk("ab1_ready", {31'b0, mem_ready}, 32'd0);
        chk("ab1_busy", {31'b0, busy}, 32'd0);
        chk("ab1_data", mem_data, 32'd0);
        $display("[TB] abort in BEAT1");

        // Asynchronous reset in the middle of BEAT0
        mem_rd = 1'b1;
        addr   = 8'h52;
        step();
        repeat (LAT) step();
        chk("ar_b0_ready", {31'b0, mem_ready}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("ar_ready", {31'b0, mem_ready}, 32'd0);
        chk("ar_busy", {31'b0, busy}, 32'd0);
        chk("ar_data", mem_data, 32'd0);
        #1 reset = 1'b0;
        mem_rd = 1'b0;
        step();
        $display("[TB] async reset mid-BEAT0");
        refill(8'h52, 1, 0, 1, 1'b0);

        // Randomized refills
        for (int t = 0; t < 12; t++) begin
            refill(AW'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
